// File: rtl/bitty_pkg.sv
// bitty_pkg: shared types and widths for the Bitty serial instruction loader
package bitty_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int INSTR_W = 16;
  localparam int BYTE_W = 8;
  localparam int CLKS_PER_BIT_DEF = 5208;
endpackage

// File: rtl/bitty_instr_rx_if.sv
// bitty_instr_rx_if: valid/ready instruction word handoff to the Bitty core
interface bitty_instr_rx_if;
  import bitty_pkg::*;
  logic [INSTR_W-1:0] word_o;
  logic word_valid_o;
  logic word_ready_i;
  modport master (output word_o, word_valid_o, input word_ready_i);
  modport slave (input word_o, word_valid_o, output word_ready_i);
endinterface

// File: rtl/bitty_uart_rx_byte.sv
// bitty_uart_rx_byte: 8N1 receiver with synchroniser, byte FSM and bit timer
module bitty_uart_rx_byte import bitty_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              rx_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_stb,
  output logic              ferr_stb
);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  rx_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] bitc, bit_n;
  logic [BYTE_W-1:0] sh, sh_n;
  logic s1, rx, prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b1;
      rx <= 1'b1;
      prev <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      bitc <= '0;
      sh <= '0;
    end else begin
      s1 <= rx_i;
      rx <= s1;
      prev <= rx;
      state <= state_n;
      cnt <= cnt_n;
      bitc <= bit_n;
      sh <= sh_n;
    end
  // Stop-bit strobes are combinational so the top registers them one cycle after the sample
  always_comb begin
    state_n = state;
    cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
    bit_n = bitc;
    sh_n = sh;
    byte_stb = 1'b0;
    ferr_stb = 1'b0;
    if (!ena) begin
      state_n = IDLE;
      cnt_n = '0;
      bit_n = '0;
    end else
      case (state)
        IDLE: if (prev && !rx) begin
          state_n = START;
          cnt_n = HALF;
        end
        START: if (cnt == '0) begin
          state_n = rx ? IDLE : DATA;
          cnt_n = FULL;
          bit_n = '0;
        end
        DATA: if (cnt == '0) begin
          sh_n = {rx, sh[BYTE_W-1:1]};
          cnt_n = FULL;
          bit_n = bitc + 3'd1;
          state_n = bitc == 3'd7 ? STOP : DATA;
        end
        default: if (cnt == '0) begin
          state_n = IDLE;
          byte_stb = rx;
          ferr_stb = !rx;
        end
      endcase
  end
  assign byte_o = sh;
endmodule

// File: rtl/bitty_instr_rx.sv
// bitty_instr_rx: pairs UART bytes low-first into 16-bit words behind a one-entry valid/ready register
module bitty_instr_rx import bitty_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              rx_i,
  bitty_instr_rx_if.master  bus,
  output logic              frame_err_o,
  output logic              overrun_o
);
  logic [BYTE_W-1:0] rx_byte, lo;
  logic [INSTR_W-1:0] word;
  logic byte_stb, ferr_stb, phase, valid, done;
  bitty_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .rx_i(rx_i),
    .byte_o(rx_byte),
    .byte_stb(byte_stb),
    .ferr_stb(ferr_stb)
  );
  assign done = byte_stb & phase;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase <= 1'b0;
      lo <= '0;
      word <= '0;
      valid <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      frame_err_o <= ferr_stb;
      phase <= !ena || ferr_stb ? 1'b0 : phase ^ byte_stb;
      if (byte_stb && !phase) lo <= rx_byte;
      if (done && (!valid || bus.word_ready_i)) begin
        word <= {rx_byte, lo};
        valid <= 1'b1;
      end else if (valid && bus.word_ready_i) valid <= 1'b0;
      if (done && valid && !bus.word_ready_i) overrun_o <= 1'b1;
    end
  assign bus.word_o = word;
  assign bus.word_valid_o = valid;
endmodule

// File: tb/tb_bitty_instr_rx.sv
// tb_bitty_instr_rx: directed UART frames with a word scoreboard checked on each handshake transfer
module tb_bitty_instr_rx;
  localparam int CPB = 8;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, rx = 1'b1, frame_err, overrun;
  int nassert = 0, nfail = 0, cyc = 0, ferr_cyc = 0, run = 0, last_run = 0;
  int rise_cyc = 0, stop_cyc = 0, xfers = 0, f0, x0;
  logic pv = 1'b0;
  logic [15:0] exp_q[$];
  bitty_instr_rx_if bus();
  bitty_instr_rx #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .rx_i(rx),
    .bus(bus.master),
    .frame_err_o(frame_err),
    .overrun_o(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (frame_err) ferr_cyc++;
    if (bus.word_valid_o && !pv) rise_cyc = cyc;
    pv = bus.word_valid_o;
    if (bus.word_valid_o) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (rst_n && bus.word_valid_o && bus.word_ready_i) begin
      xfers++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sb_word", 32'(bus.word_o), 32'(exp_q.pop_front()));
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(logic [7:0] b, logic stop = 1'b1, bit pulse = 1'b0);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    stop_cyc = cyc;
    if (pulse) begin
      tick(CPB - 2);
      bus.word_ready_i = 1'b1;
      tick(1);
      bus.word_ready_i = 1'b0;
      tick(1);
    end else tick(CPB);
    rx = 1'b1;
    tick(4);
  endtask
  task automatic send_word(logic [15:0] w, bit push);
    if (push) exp_q.push_back(w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask
  task automatic drain(string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
    check(tag, 32'(exp_q.size()), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.word_ready_i = 1'b1;
    tick(3);
    check("rst_word", 32'(bus.word_o), 0);
    check("rst_valid", 32'(bus.word_valid_o), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun), 0);
    rst_n = 1'b1;
    tick(5);
    send_word(16'h1234, 1);
    check("t1_rise_in_stop", 32'((rise_cyc - stop_cyc) >= 2 && (rise_cyc - stop_cyc) <= CPB), 1);
    drain("t1_drain");
    check("t1_valid_len", 32'(last_run), 1);
    check("t1_ferr", 32'(ferr_cyc), 0);
    check("t1_ovr", 32'(overrun), 0);
    bus.word_ready_i = 1'b0;
    exp_q.push_back(16'hDEAD);
    send_byte(8'hAD);
    send_byte(8'hDE);
    check("t2_valid", 32'(bus.word_valid_o), 1);
    check("t2_word", 32'(bus.word_o), 32'h0000DEAD);
    check("t2_ovr_before", 32'(overrun), 0);
    send_byte(8'hEF);
    send_byte(8'hBE);
    check("t2_word_held", 32'(bus.word_o), 32'h0000DEAD);
    check("t2_ovr", 32'(overrun), 1);
    bus.word_ready_i = 1'b1;
    drain("t2_drain");
    tick(2);
    check("t2_valid_drop", 32'(bus.word_valid_o), 0);
    check("t2_ovr_sticky", 32'(overrun), 1);
    f0 = ferr_cyc;
    send_byte(8'h55, 1'b0);
    check("t3_ferr_once", 32'(ferr_cyc - f0), 1);
    check("t3_no_word", 32'(bus.word_valid_o), 0);
    send_word(16'h0001, 1);
    drain("t3_drain");
    f0 = ferr_cyc;
    x0 = xfers;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(20);
    check("t4_no_ferr", 32'(ferr_cyc - f0), 0);
    check("t4_no_word", 32'(xfers - x0), 0);
    send_word(16'h0F0F ^ 16'hFF00, 1);
    drain("t4_drain");
    send_byte(8'h33);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      tick(CPB);
    end
    tick(3);
    ena = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(3);
    ena = 1'b1;
    tick(4);
    send_word(16'h1122, 1);
    drain("t5_drain");
    bus.word_ready_i = 1'b0;
    send_word(16'h9999, 0);
    check("t5_valid_pre_rst", 32'(bus.word_valid_o), 1);
    rx = 1'b0;
    tick(CPB + 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_word", 32'(bus.word_o), 0);
    check("t5_rst_valid", 32'(bus.word_valid_o), 0);
    check("t5_rst_ovr", 32'(overrun), 0);
    check("t5_rst_ferr", 32'(frame_err), 0);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    bus.word_ready_i = 1'b1;
    send_word(16'h3344, 1);
    drain("t5_post_rst_drain");
    bus.word_ready_i = 1'b0;
    send_word(16'h5AA5, 1);
    check("t6_valid_old", 32'(bus.word_valid_o), 1);
    x0 = xfers;
    exp_q.push_back(16'hC33C);
    send_byte(8'h3C);
    send_byte(8'hC3, 1'b1, 1'b1);
    check("t6_old_taken", 32'(xfers - x0), 1);
    check("t6_valid_kept", 32'(bus.word_valid_o), 1);
    check("t6_word_new", 32'(bus.word_o), 32'h0000C33C);
    check("t6_ovr", 32'(overrun), 0);
    check("t6_pending", 32'(exp_q.size()), 1);
    bus.word_ready_i = 1'b1;
    drain("t6_drain");
    tick(2);
    check("t6_valid_drop", 32'(bus.word_valid_o), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
